// File: rtl/matrix_pkg.sv
// Shared LED matrix definitions: sink FSM encoding, pixel byte phases,
// RGB888 width and default MAC/EtherType used by leddriver and the TX path.
package matrix_pkg;

  localparam int BYTE_W = 8;
  localparam int RGB_W  = 24;

  localparam logic [47:0] DEFAULT_MAC      = 48'hDAD1D2D3D4D5;
  localparam logic [47:0] BCAST_MAC        = 48'hFFFFFFFFFFFF;
  localparam logic [15:0] DEFAULT_ETH_TYPE = 16'h88B5;

  // Byte position inside an R,G,B triplet
  localparam logic [1:0] PHASE_R = 2'd0;
  localparam logic [1:0] PHASE_G = 2'd1;
  localparam logic [1:0] PHASE_B = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_ROW = 3'd1,
    ST_HDR_COL = 3'd2,
    ST_PIXELS  = 3'd3,
    ST_DRAIN   = 3'd4
  } sink_state_e;

endpackage

// File: rtl/rgb_packer.sv
// Collects R,G,B payload bytes into one RGB888 word; pixel_valid marks the
// beat carrying the blue byte, with the completed word on pixel.
module rgb_packer
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              pixel_valid,
  output logic [RGB_W-1:0]  pixel
);

  logic [1:0]        phase_r;
  logic [BYTE_W-1:0] red_r;
  logic [BYTE_W-1:0] green_r;

  // Byte phase counter and red/green holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= PHASE_R;
      red_r   <= 8'h00;
      green_r <= 8'h00;
    end else if (clear) begin
      phase_r <= PHASE_R;
    end else if (byte_valid) begin
      case (phase_r)
        PHASE_R: begin
          red_r   <= byte_data;
          phase_r <= PHASE_G;
        end
        PHASE_G: begin
          green_r <= byte_data;
          phase_r <= PHASE_B;
        end
        PHASE_B: phase_r <= PHASE_R;
        default: phase_r <= PHASE_R;
      endcase
    end
  end

  assign pixel_valid = byte_valid && (phase_r == PHASE_B);
  assign pixel       = {red_r, green_r, byte_data};

endmodule

// File: rtl/eth_line_sink.sv
// Writes one LED panel line per filtered Ethernet frame into the framebuffer;
// payload is row, start column, then RGB triplets. Rejected payloads are drained.
module eth_line_sink
  import matrix_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR     = DEFAULT_MAC,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter logic [15:0] ETH_TYPE     = DEFAULT_ETH_TYPE,
  parameter int          PANEL_COLS   = 64,
  parameter int          PANEL_ROWS   = 32,
  parameter int          COL_W        = $clog2(PANEL_COLS),
  parameter int          ROW_W        = $clog2(PANEL_ROWS),
  parameter int          CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_eth_hdr_valid,
  output logic                   s_eth_hdr_ready,
  input  logic [47:0]            s_eth_dest_mac,
  input  logic [15:0]            s_eth_type,
  input  logic [7:0]             s_payload_tdata,
  input  logic                   s_payload_tvalid,
  output logic                   s_payload_tready,
  input  logic                   s_payload_tlast,
  input  logic                   s_payload_tuser,
  output logic                   fb_wr_en,
  output logic [ROW_W+COL_W-1:0] fb_wr_addr,
  output logic [RGB_W-1:0]       fb_wr_data,
  output logic                   line_done,
  output logic [ROW_W-1:0]       line_idx,
  output logic [CNT_W-1:0]       good_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [BYTE_W-1:0] ROW_LIM = BYTE_W'(PANEL_ROWS);
  localparam logic [BYTE_W-1:0] COL_BYTE_LIM = BYTE_W'(PANEL_COLS);
  localparam logic [COL_W:0]    COL_LIM = (COL_W+1)'(PANEL_COLS);

  function automatic logic hdr_match(input logic [47:0] mac, input logic [15:0] etype);
    return (etype == ETH_TYPE) && ((mac == MAC_ADDR) || (ACCEPT_BCAST && (mac == BCAST_MAC)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  sink_state_e           state_r;
  logic                  hdr_ready_r;
  logic                  tready_r;
  logic                  range_drop_r;
  logic [ROW_W-1:0]      row_r;
  logic [COL_W:0]        col_r;
  logic                  fb_wr_en_r;
  logic [ROW_W+COL_W-1:0] fb_wr_addr_r;
  logic [RGB_W-1:0]      fb_wr_data_r;
  logic                  line_done_r;
  logic [ROW_W-1:0]      line_idx_r;
  logic [CNT_W-1:0]      good_cnt_r;
  logic [CNT_W-1:0]      drop_cnt_r;
  logic                  beat_s;
  logic                  pix_valid_s;
  logic [RGB_W-1:0]      pixel_s;

  assign beat_s = s_payload_tvalid && tready_r;

  rgb_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (state_r != ST_PIXELS),
    .byte_valid  (beat_s && (state_r == ST_PIXELS)),
    .byte_data   (s_payload_tdata),
    .pixel_valid (pix_valid_s),
    .pixel       (pixel_s)
  );

  // Frame FSM with all handshake, framebuffer and status outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      hdr_ready_r  <= 1'b0;
      tready_r     <= 1'b0;
      range_drop_r <= 1'b0;
      row_r        <= '0;
      col_r        <= '0;
      fb_wr_en_r   <= 1'b0;
      fb_wr_addr_r <= '0;
      fb_wr_data_r <= '0;
      line_done_r  <= 1'b0;
      line_idx_r   <= '0;
      good_cnt_r   <= '0;
      drop_cnt_r   <= '0;
    end else begin
      fb_wr_en_r  <= 1'b0;
      line_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (s_eth_hdr_valid && hdr_ready_r) begin
            hdr_ready_r  <= 1'b0;
            tready_r     <= 1'b1;
            range_drop_r <= 1'b0;
            state_r      <= hdr_match(s_eth_dest_mac, s_eth_type) ? ST_HDR_ROW : ST_DRAIN;
          end else begin
            hdr_ready_r <= 1'b1;
          end
        end
        ST_HDR_ROW: begin
          if (beat_s) begin
            if (s_payload_tlast) begin
              drop_cnt_r  <= sat_inc(drop_cnt_r);
              tready_r    <= 1'b0;
              hdr_ready_r <= 1'b1;
              state_r     <= ST_IDLE;
            end else if (s_payload_tdata >= ROW_LIM) begin
              range_drop_r <= 1'b1;
              state_r      <= ST_DRAIN;
            end else begin
              row_r   <= s_payload_tdata[ROW_W-1:0];
              state_r <= ST_HDR_COL;
            end
          end
        end
        ST_HDR_COL: begin
          if (beat_s) begin
            if (s_payload_tlast) begin
              drop_cnt_r  <= sat_inc(drop_cnt_r);
              tready_r    <= 1'b0;
              hdr_ready_r <= 1'b1;
              state_r     <= ST_IDLE;
            end else if (s_payload_tdata >= COL_BYTE_LIM) begin
              range_drop_r <= 1'b1;
              state_r      <= ST_DRAIN;
            end else begin
              col_r   <= {1'b0, s_payload_tdata[COL_W-1:0]};
              state_r <= ST_PIXELS;
            end
          end
        end
        ST_PIXELS: begin
          // Pixels past the last column are swallowed, never wrapped
          if (pix_valid_s && (col_r < COL_LIM)) begin
            fb_wr_en_r   <= 1'b1;
            fb_wr_addr_r <= {row_r, col_r[COL_W-1:0]};
            fb_wr_data_r <= pixel_s;
            col_r        <= col_r + {{COL_W{1'b0}}, 1'b1};
          end
          if (beat_s && s_payload_tlast) begin
            if (s_payload_tuser) begin
              drop_cnt_r <= sat_inc(drop_cnt_r);
            end else begin
              line_done_r <= 1'b1;
              line_idx_r  <= row_r;
              good_cnt_r  <= sat_inc(good_cnt_r);
            end
            tready_r    <= 1'b0;
            hdr_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (beat_s && s_payload_tlast) begin
            if (range_drop_r) begin
              drop_cnt_r <= sat_inc(drop_cnt_r);
            end
            tready_r    <= 1'b0;
            hdr_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          tready_r    <= 1'b0;
          hdr_ready_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_eth_hdr_ready  = hdr_ready_r;
  assign s_payload_tready = tready_r;
  assign fb_wr_en         = fb_wr_en_r;
  assign fb_wr_addr       = fb_wr_addr_r;
  assign fb_wr_data       = fb_wr_data_r;
  assign line_done        = line_done_r;
  assign line_idx         = line_idx_r;
  assign good_cnt         = good_cnt_r;
  assign drop_cnt         = drop_cnt_r;

endmodule

// File: tb/tb_eth_line_sink.sv
// Directed bench for eth_line_sink: frame filtering, line writes, range drops,
// bad-frame handling, tvalid gaps and mid-frame reset.
module tb_eth_line_sink;
  import matrix_pkg::*;

  localparam logic [47:0] MAC   = 48'hDAD1D2D3D4D5;
  localparam logic [15:0] ETYPE = 16'h88B5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_eth_hdr_valid = 1'b0;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac = 48'h0;
  logic [15:0] s_eth_type = 16'h0;
  logic [7:0]  s_payload_tdata = 8'h00;
  logic        s_payload_tvalid = 1'b0;
  logic        s_payload_tready;
  logic        s_payload_tlast = 1'b0;
  logic        s_payload_tuser = 1'b0;
  logic        fb_wr_en;
  logic [10:0] fb_wr_addr;
  logic [23:0] fb_wr_data;
  logic        line_done;
  logic [4:0]  line_idx;
  logic [15:0] good_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int nwr = 0;
  int nld = 0;
  logic [31:0] wr_addr_a [0:1023];
  logic [31:0] wr_data_a [0:1023];

  eth_line_sink dut (
    .clk              (clk),
    .rst              (rst),
    .s_eth_hdr_valid  (s_eth_hdr_valid),
    .s_eth_hdr_ready  (s_eth_hdr_ready),
    .s_eth_dest_mac   (s_eth_dest_mac),
    .s_eth_type       (s_eth_type),
    .s_payload_tdata  (s_payload_tdata),
    .s_payload_tvalid (s_payload_tvalid),
    .s_payload_tready (s_payload_tready),
    .s_payload_tlast  (s_payload_tlast),
    .s_payload_tuser  (s_payload_tuser),
    .fb_wr_en         (fb_wr_en),
    .fb_wr_addr       (fb_wr_addr),
    .fb_wr_data       (fb_wr_data),
    .line_done        (line_done),
    .line_idx         (line_idx),
    .good_cnt         (good_cnt),
    .drop_cnt         (drop_cnt)
  );

  always #5 clk = ~clk;

  // Write and line_done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (fb_wr_en) begin
      if (nwr < 1024) begin
        wr_addr_a[nwr] = {21'h0, fb_wr_addr};
        wr_data_a[nwr] = {8'h00, fb_wr_data};
      end
      nwr = nwr + 1;
    end
    if (line_done) nld = nld + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_byte(input int k);
    return 8'(k) ^ 8'h3C;
  endfunction

  task automatic send_hdr(input logic [47:0] mac, input logic [15:0] etype);
    int n;
    s_eth_hdr_valid = 1'b1;
    s_eth_dest_mac  = mac;
    s_eth_type      = etype;
    n = 0;
    while (!s_eth_hdr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_eth_hdr_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL hdr_timeout: hdr_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
    s_eth_hdr_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    int n;
    s_payload_tvalid = 1'b1;
    s_payload_tdata  = d;
    s_payload_tlast  = last;
    s_payload_tuser  = user;
    n = 0;
    while (!s_payload_tready && n < 50) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    if (!s_payload_tready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL tready_timeout: tready stayed 0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
    s_payload_tvalid = 1'b0;
    s_payload_tlast  = 1'b0;
    s_payload_tuser  = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] mac, input logic [15:0] etype,
                            input logic [7:0] row, input logic [7:0] col,
                            input int npix, input logic user, input bit gaps);
    int total;
    logic [7:0] d;
    total = npix + 2;
    send_hdr(mac, etype);
    for (int k = 0; k < total; k++) begin
      d = (k == 0) ? row : (k == 1) ? col : pix_byte(k - 2);
      send_byte(d, (k == total - 1), (k == total - 1) ? user : 1'b0);
      if (gaps && ($urandom_range(0, 1) == 1)) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0;
    int l0;
    // Reset state
    #2;
    check_val("rst_hdr_ready", {31'h0, s_eth_hdr_ready}, 32'd0);
    check_val("rst_tready", {31'h0, s_payload_tready}, 32'd0);
    check_val("rst_wr_en", {31'h0, fb_wr_en}, 32'd0);
    check_val("rst_good", {16'h0, good_cnt}, 32'd0);
    check_val("rst_drop", {16'h0, drop_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_hdr_ready", {31'h0, s_eth_hdr_ready}, 32'd1);

    // 1: full line at row 5
    w0 = nwr; l0 = nld;
    send_frame(MAC, ETYPE, 8'd5, 8'd0, 192, 1'b0, 1'b0);
    check_val("t1_nwr", 32'(nwr - w0), 32'd64);
    check_val("t1_addr0", wr_addr_a[w0], 32'd320);
    check_val("t1_addr63", wr_addr_a[w0 + 63], 32'd383);
    check_val("t1_data0", wr_data_a[w0], 32'h003C3D3E);
    check_val("t1_data63", wr_data_a[w0 + 63], 32'h00818283);
    check_val("t1_line_done", 32'(nld - l0), 32'd1);
    check_val("t1_line_idx", {27'h0, line_idx}, 32'd5);
    check_val("t1_good", {16'h0, good_cnt}, 32'd1);

    // 2: wrong MAC drained without stalls or counting, then a good frame
    w0 = nwr; l0 = nld; stalls = 0;
    send_frame(48'h001122334455, ETYPE, 8'd0, 8'd0, 98, 1'b0, 1'b0);
    check_val("t2_nwr", 32'(nwr - w0), 32'd0);
    check_val("t2_stalls", 32'(stalls), 32'd0);
    check_val("t2_drop", {16'h0, drop_cnt}, 32'd0);
    check_val("t2_line_done", 32'(nld - l0), 32'd0);
    w0 = nwr;
    send_frame(MAC, ETYPE, 8'd1, 8'd0, 3, 1'b0, 1'b0);
    check_val("t2_next_nwr", 32'(nwr - w0), 32'd1);
    check_val("t2_next_addr", wr_addr_a[w0], 32'd64);
    check_val("t2_good", {16'h0, good_cnt}, 32'd2);

    // Wrong EtherType is ignored, broadcast MAC is accepted
    w0 = nwr;
    send_frame(MAC, 16'h0800, 8'd2, 8'd0, 3, 1'b0, 1'b0);
    check_val("etype_nwr", 32'(nwr - w0), 32'd0);
    check_val("etype_good", {16'h0, good_cnt}, 32'd2);
    w0 = nwr;
    send_frame(48'hFFFFFFFFFFFF, ETYPE, 8'd2, 8'd0, 3, 1'b0, 1'b0);
    check_val("bcast_nwr", 32'(nwr - w0), 32'd1);
    check_val("bcast_good", {16'h0, good_cnt}, 32'd3);

    // 3: row out of range
    w0 = nwr; l0 = nld;
    send_frame(MAC, ETYPE, 8'd40, 8'd0, 30, 1'b0, 1'b0);
    check_val("t3_nwr", 32'(nwr - w0), 32'd0);
    check_val("t3_drop", {16'h0, drop_cnt}, 32'd1);
    check_val("t3_line_done", 32'(nld - l0), 32'd0);

    // 4: start at col 62, writes stop at the line end
    w0 = nwr; l0 = nld;
    send_frame(MAC, ETYPE, 8'd7, 8'd62, 12, 1'b0, 1'b0);
    check_val("t4_nwr", 32'(nwr - w0), 32'd2);
    check_val("t4_addr0", wr_addr_a[w0], 32'd510);
    check_val("t4_addr1", wr_addr_a[w0 + 1], 32'd511);
    check_val("t4_line_done", 32'(nld - l0), 32'd1);
    check_val("t4_line_idx", {27'h0, line_idx}, 32'd7);
    check_val("t4_good", {16'h0, good_cnt}, 32'd4);

    // 5: bad frame, with and without tvalid gaps
    for (int g = 0; g < 2; g++) begin
      w0 = nwr; l0 = nld;
      send_frame(MAC, ETYPE, 8'd3, 8'd10, 7, 1'b1, (g == 1));
      check_val("t5_nwr", 32'(nwr - w0), 32'd2);
      check_val("t5_addr1", wr_addr_a[w0 + 1], 32'd203);
      check_val("t5_data1", wr_data_a[w0 + 1], 32'h003F3839);
      check_val("t5_line_done", 32'(nld - l0), 32'd0);
      check_val("t5_drop", {16'h0, drop_cnt}, 32'(2 + g));
      check_val("t5_good", {16'h0, good_cnt}, 32'd4);
    end

    // 6: reset in the middle of the pixel stream
    send_hdr(MAC, ETYPE);
    send_byte(8'd4, 1'b0, 1'b0);
    send_byte(8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) send_byte(pix_byte(k), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_val("t6_wr_en", {31'h0, fb_wr_en}, 32'd0);
    check_val("t6_hdr_ready", {31'h0, s_eth_hdr_ready}, 32'd0);
    check_val("t6_tready", {31'h0, s_payload_tready}, 32'd0);
    check_val("t6_good", {16'h0, good_cnt}, 32'd0);
    check_val("t6_drop", {16'h0, drop_cnt}, 32'd0);
    check_val("t6_line_idx", {27'h0, line_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    w0 = nwr;
    send_frame(MAC, ETYPE, 8'd4, 8'd0, 3, 1'b0, 1'b0);
    check_val("t6_nwr", 32'(nwr - w0), 32'd1);
    check_val("t6_addr", wr_addr_a[w0], 32'd256);
    check_val("t6_data", wr_data_a[w0], 32'h003C3D3E);
    check_val("t6_good_after", {16'h0, good_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
